// File: rtl/memory_wait.sv
// Unified instruction/data memory: registered single-cycle fetch port plus a wait-stated,
// byte-enabled data port. Define MEM_RANGE_CHECK_EN to flag out-of-range/misaligned accesses.
module memory_wait #(
    parameter int    DATA_W      = 32,
    parameter int    DEPTH       = 64,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [31:0]           instructionAddress,
    output logic [DATA_W-1:0]     instruction,
    output logic                  i_valid,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [31:0]           MemAddress,
    input  logic [DATA_W-1:0]     WriteData,
    input  logic [DATA_W/8-1:0]   ByteEn,
    output logic [DATA_W-1:0]     ReadData,
    output logic                  MemReady,
    output logic                  MemError
);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          NB        = DATA_W / 8;
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              op_wr_q;
    logic              err_q;
    logic [AW-1:0]     idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]     be_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;
    logic [DATA_W-1:0] instr_q;
    logic              ivalid_q;

    logic [AW-1:0]     fetch_idx;
    logic [AW-1:0]     req_idx;
    logic              fetch_oob;
    logic              req_err;
    logic              mem_we;
    logic              unused_addr;

    assign fetch_idx = instructionAddress[AW+1:2];
    assign req_idx   = MemAddress[AW+1:2];

`ifdef MEM_RANGE_CHECK_EN
    logic merr_q;
    assign fetch_oob   = (instructionAddress >= MEM_BYTES);
    assign req_err     = (MemAddress >= MEM_BYTES) || (MemAddress[1:0] != 2'b00);
    assign unused_addr = ^instructionAddress[1:0];
    assign MemError    = merr_q;
`else
    assign fetch_oob   = 1'b0;
    assign req_err     = 1'b0;
    assign unused_addr = ^{instructionAddress[31:AW+2], instructionAddress[1:0],
                           MemAddress[31:AW+2], MemAddress[1:0]};
    assign MemError    = 1'b0;
`endif

    // Memory contents survive reset; they start at zero.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
    end

    assign mem_we = (state_q == S_WAIT) && (cnt_q == 4'd0) && op_wr_q && !err_q;

    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (be_q[b]) mem_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
    end

    // Fetch reads the pre-write word when a data write lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            ivalid_q <= 1'b0;
        end else begin
            ivalid_q <= i_req;
            if (i_req) instr_q <= fetch_oob ? '0 : mem_q[fetch_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
            merr_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (MemRead || MemWrite) begin
                        op_wr_q <= MemWrite;
                        err_q   <= req_err;
                        idx_q   <= req_idx;
                        wdata_q <= WriteData;
                        be_q    <= ByteEn;
                        cnt_q   <= WAIT_INIT;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (!op_wr_q) rdata_q <= err_q ? '0 : mem_q[idx_q];
                        ready_q <= 1'b1;
`ifdef MEM_RANGE_CHECK_EN
                        merr_q  <= err_q;
`endif
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready_q <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
                    merr_q  <= 1'b0;
`endif
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign instruction = instr_q;
    assign i_valid     = ivalid_q;
    assign ReadData    = rdata_q;
    assign MemReady    = ready_q;
endmodule
